// File: rtl/coherence_ctrl.sv
// Coherence controller: arbitrates per-core icache/dcache requests onto one RAM port and
// snoops/invalidates the other dcaches when a dcache line changes state.
module coherence_ctrl #(
  parameter int unsigned CPUS = 2,
  parameter int unsigned AW   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CPUS-1:0]   iREN,
  input  logic [CPUS*AW-1:0] iaddr,
  output logic [CPUS-1:0]   iwait,
  output logic [CPUS*AW-1:0] iload,
  input  logic [CPUS-1:0]   dREN,
  input  logic [CPUS-1:0]   dWEN,
  input  logic [CPUS*AW-1:0] daddr,
  input  logic [CPUS*AW-1:0] dstore,
  input  logic [CPUS-1:0]   ccwrite,
  input  logic [CPUS-1:0]   cctrans,
  output logic [CPUS-1:0]   dwait,
  output logic [CPUS*AW-1:0] dload,
  output logic [CPUS-1:0]   ccwait,
  output logic [CPUS-1:0]   ccinv,
  output logic [CPUS*AW-1:0] ccsnoopaddr,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [AW-1:0]     ramaddr,
  output logic [AW-1:0]     ramstore,
  input  logic [AW-1:0]     ramload,
  input  logic              ramready
);

  localparam int unsigned IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic [1:0] {StIdle, StSnoop, StAccess} state_e;

  state_e        state_q;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] gnt_q;
  logic          gnt_d_q;

  logic [CPUS-1:0] dreq;
  logic            pick_valid;
  logic            pick_d;
  logic [IW-1:0]   pick_k;
  logic            done;
  logic [31:0]     g_base;

  function automatic logic [IW-1:0] rr_add(input logic [IW-1:0] base, input int unsigned off);
    return IW'((32'(base) + off) % CPUS);
  endfunction

  assign g_base = 32'(gnt_q) * AW;
  // A reset cycle never signals completion, even if ramready happens to be high.
  assign done   = (state_q == StAccess) && ramready && !RST;

  // Dcache requests first, then icache; each kind scanned round-robin from rr_q.
  always_comb begin
    pick_valid = 1'b0;
    pick_d     = 1'b0;
    pick_k     = '0;
    dreq       = dREN | dWEN;
    for (int unsigned off = 0; off < CPUS; off++) begin
      if (!pick_valid && dreq[rr_add(rr_q, off)]) begin
        pick_valid = 1'b1;
        pick_d     = 1'b1;
        pick_k     = rr_add(rr_q, off);
      end
    end
    for (int unsigned off = 0; off < CPUS; off++) begin
      if (!pick_valid && iREN[rr_add(rr_q, off)]) begin
        pick_valid = 1'b1;
        pick_k     = rr_add(rr_q, off);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      rr_q    <= '0;
      gnt_q   <= '0;
      gnt_d_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            gnt_q   <= pick_k;
            gnt_d_q <= pick_d;
            state_q <= (pick_d && cctrans[pick_k]) ? StSnoop : StAccess;
          end
        end
        StSnoop: state_q <= StAccess;
        StAccess: begin
          if (ramready) begin
            state_q <= StIdle;
            rr_q    <= rr_add(gnt_q, 1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode the registered state/grant; completion follows ramready in the same cycle.
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    if (state_q == StSnoop) begin
      for (int unsigned j = 0; j < CPUS; j++) begin
        if (IW'(j) != gnt_q) begin
          ccwait[j]                 = 1'b1;
          ccinv[j]                  = ccwrite[gnt_q];
          ccsnoopaddr[j*AW +: AW]   = daddr[g_base +: AW];
        end
      end
    end
    if (state_q == StAccess) begin
      if (gnt_d_q) begin
        ramREN   = dREN[gnt_q];
        ramWEN   = dWEN[gnt_q];
        ramaddr  = daddr[g_base +: AW];
        ramstore = dstore[g_base +: AW];
        if (done) begin
          dwait[gnt_q] = 1'b0;
          if (dREN[gnt_q]) dload[g_base +: AW] = ramload;
        end
      end else begin
        ramREN  = iREN[gnt_q];
        ramaddr = iaddr[g_base +: AW];
        if (done) begin
          iwait[gnt_q]        = 1'b0;
          iload[g_base +: AW] = ramload;
        end
      end
    end
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
// Bench for coherence_ctrl: table of single transactions, hand sequences for contention and
// reset, RAM model with programmable latency, and a scoreboard of expected completions.
module tb_coherence_ctrl;

  localparam int CPUS = 2;
  localparam int AW   = 32;

  logic              CLK;
  logic              RST;
  logic [CPUS-1:0]   iREN, iwait, dREN, dWEN, ccwrite, cctrans, dwait, ccwait, ccinv;
  logic [CPUS*AW-1:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic              ramREN, ramWEN, ramready;
  logic [AW-1:0]     ramaddr, ramstore, ramload;

  coherence_ctrl #(.CPUS(CPUS), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite),
    .cctrans(cctrans), .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_d;
    int          core;
    bit          wr;
    bit          trans;
    bit          cw;
    logic [31:0] addr;
    logic [31:0] store;
    int          lat;
    logic [31:0] load;
    int          issue_cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        tbl[7];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0, failures = 0, cyc = 0, ram_cnt = 0, ram_lat = 1, rr_model = 0;
  int          snoop_cnt = 0;
  logic [CPUS-1:0] snoop_w = '0, snoop_inv = '0, done_i = '0, done_d = '0, rel_i, rel_d;
  logic [31:0] snoop_addr = '0;

  function automatic logic [31:0] ref_load(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ref_load(a);
  endfunction

  function automatic logic [31:0] t5_addr(input int c, input int idx);
    return 32'h3000 + 32'(c << 8) + 32'(idx * 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [CPUS-1:0] ci, cd, exp_i, exp_d, mask;
    exp_t e;
    if (ramREN && ramWEN) check("ram_both_strobes", 32'(ramREN & ramWEN), 32'd0);
    if (ccwait != '0) begin
      snoop_cnt++;
      for (int k = 0; k < CPUS; k++) if (ccwait[k]) snoop_addr = ccsnoopaddr[k*AW +: AW];
    end
    snoop_w   |= ccwait;
    snoop_inv |= ccinv;
    ci = ~iwait;
    cd = ~dwait;
    if ((ci | cd) != '0) begin
      done_i = ci;
      done_d = cd;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_completion actual_i=%b actual_d=%b required=none", ci, cd);
      end else begin
        e     = q.pop_front();
        exp_i = '0;
        exp_d = '0;
        if (e.is_d) exp_d[e.core] = 1'b1;
        else        exp_i[e.core] = 1'b1;
        check("icache_done", 32'(ci), 32'(exp_i));
        check("dcache_done", 32'(cd), 32'(exp_d));
        check("ram_wen", 32'(ramWEN), 32'(e.wr));
        check("ram_ren", 32'(ramREN), 32'(!e.wr));
        check("ram_addr", ramaddr, e.addr);
        if (e.wr) check("ram_store", ramstore, e.store);
        else check("load", e.is_d ? dload[e.core*AW +: AW] : iload[e.core*AW +: AW], e.load);
        mask = '1;
        mask[e.core] = 1'b0;
        if (!e.trans) mask = '0;
        check("snoop_cycles", 32'(snoop_cnt), 32'(e.trans));
        check("snoop_wait", 32'(snoop_w), 32'(mask));
        check("snoop_inv", 32'(snoop_inv), e.cw ? 32'(mask) : 32'd0);
        if (e.trans) check("snoop_addr", snoop_addr, e.addr);
        if (e.lat != 0) check("latency", 32'(cyc - e.issue_cyc), 32'(int'(e.trans) + e.lat));
        rr_model = (e.core + 1) % CPUS;
      end
      snoop_cnt = 0;
      snoop_w   = '0;
      snoop_inv = '0;
    end
  endtask

  // Sample at negedge, then update RAM model and release finished requesters after posedge.
  task automatic tick();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
    cyc++;
    if (ramready || !(ramREN || ramWEN)) begin
      ramready = 1'b0;
      ram_cnt  = 0;
    end else begin
      ram_cnt++;
      if (ram_cnt >= ram_lat) begin
        ramready = 1'b1;
        ramload  = mem_rd(ramaddr);
        if (ramWEN) mem[ramaddr] = ramstore;
      end
    end
    rel_i = done_i;
    rel_d = done_d;
    for (int k = 0; k < CPUS; k++) begin
      if (done_i[k]) iREN[k] = 1'b0;
      if (done_d[k]) begin
        dREN[k]    = 1'b0;
        dWEN[k]    = 1'b0;
        cctrans[k] = 1'b0;
        ccwrite[k] = 1'b0;
      end
    end
    done_i = '0;
    done_d = '0;
  endtask

  task automatic issue(input exp_t e);
    if (e.is_d) begin
      dREN[e.core]              = !e.wr;
      dWEN[e.core]              = e.wr;
      cctrans[e.core]           = e.trans;
      ccwrite[e.core]           = e.cw;
      daddr[e.core*AW +: AW]    = e.addr;
      dstore[e.core*AW +: AW]   = e.store;
    end else begin
      iREN[e.core]              = 1'b1;
      iaddr[e.core*AW +: AW]    = e.addr;
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
      iREN = '0;
      dREN = '0;
      dWEN = '0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, e2;
    int   cnt[CPUS];
    int   c0;
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramready = 1'b0; ramload = '0;
    mem[32'h100] = 32'hDEADBEEF;
    //          is_d core wr tr cw addr        store          lat load
    tbl[0] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h100,  32'h0,        3, 32'hDEADBEEF,      0};
    tbl[1] = '{1'b1, 0, 1'b1, 1'b1, 1'b1, 32'h2040, 32'h5,        2, 32'h0,             0};
    tbl[2] = '{1'b1, 0, 1'b0, 1'b0, 1'b0, 32'h2040, 32'h0,        1, 32'h5,             0};
    tbl[3] = '{1'b1, 1, 1'b0, 1'b1, 1'b0, 32'h44,   32'h0,        1, ref_load(32'h44),  0};
    tbl[4] = '{1'b0, 1, 1'b0, 1'b0, 1'b0, 32'h200,  32'h0,        2, ref_load(32'h200), 0};
    tbl[5] = '{1'b1, 1, 1'b1, 1'b0, 1'b0, 32'h300,  32'hCAFEF00D, 4, 32'h0,             0};
    tbl[6] = '{1'b1, 1, 1'b0, 1'b1, 1'b1, 32'h304,  32'h0,        1, ref_load(32'h304), 0};

    // Reset state
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_iwait", 32'(iwait), 32'h3);
    check("rst_dwait", 32'(dwait), 32'h3);
    check("rst_ccwait", 32'(ccwait), 32'h0);
    check("rst_ramren", 32'(ramREN), 32'h0);
    check("rst_ramwen", 32'(ramWEN), 32'h0);
    check("rst_ramaddr", ramaddr, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Single transactions
    for (int i = 0; i < 7; i++) begin
      e = tbl[i];
      ram_lat = e.lat;
      issue(e);
      e.issue_cyc = cyc;
      q.push_back(e);
      drain(60);
    end

    // Simultaneous icache 0 and dcache 1: dcache wins
    ram_lat = 2;
    e  = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h180, 32'h0, 0, ref_load(32'h180), 0};
    e2 = '{1'b1, 1, 1'b0, 1'b0, 1'b0, 32'h1C0, 32'h0, 0, ref_load(32'h1C0), 0};
    issue(e);
    issue(e2);
    q.push_back(e2);
    q.push_back(e);
    drain(60);

    // Both dcaches requesting continuously: strict alternation from the rr pointer
    ram_lat = 1;
    c0 = rr_model;
    for (int n = 0; n < 20; n++) begin
      e = '{1'b1, (c0 + n) % CPUS, 1'b0, 1'b0, 1'b0, t5_addr((c0 + n) % CPUS, n / 2), 32'h0, 0,
            ref_load(t5_addr((c0 + n) % CPUS, n / 2)), 0};
      q.push_back(e);
    end
    for (int k = 0; k < CPUS; k++) begin
      e = '{1'b1, k, 1'b0, 1'b0, 1'b0, t5_addr(k, 0), 32'h0, 0, 32'h0, 0};
      issue(e);
      cnt[k] = 1;
    end
    for (int n = 0; n < 200 && q.size() != 0; n++) begin
      tick();
      for (int k = 0; k < CPUS; k++) begin
        if (rel_d[k] && cnt[k] < 10) begin
          e = '{1'b1, k, 1'b0, 1'b0, 1'b0, t5_addr(k, cnt[k]), 32'h0, 0, 32'h0, 0};
          issue(e);
          cnt[k]++;
        end
      end
    end
    drain(4);

    // Reset during ACCESS abandons the access without a completion
    ram_lat = 20;
    e = '{1'b1, 0, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0, 0, 32'h0, 0};
    issue(e);
    tick();
    tick();
    @(negedge CLK);
    check("acc_before_rst", 32'(ramREN), 32'h1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    ramready = 1'b1;
    ramload  = 32'h12345678;
    @(negedge CLK);
    check("rst_acc_dwait", 32'(dwait), 32'h3);
    check("rst_acc_iwait", 32'(iwait), 32'h3);
    @(posedge CLK);
    #1;
    dREN = '0;
    ramready = 1'b0;
    @(negedge CLK);
    check("rst_acc_ramren", 32'(ramREN), 32'h0);
    check("rst_acc_ramwen", 32'(ramWEN), 32'h0);
    check("rst_acc_dwait2", 32'(dwait), 32'h3);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    ram_cnt = 0;
    rr_model = 0;

    // Recovery after reset
    ram_lat = 1;
    e = '{1'b0, 1, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0, 1, ref_load(32'h600), 0};
    issue(e);
    e.issue_cyc = cyc;
    q.push_back(e);
    drain(60);
    tick();
    check("queue_empty", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
